// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_sequencer
// Brief    : Multi-cycle DATA_WIDTH adder reusing one SLICE_WIDTH carry-skip
//            adder, LSB slice first, with valid/ready on both sides.
//            Optional macro WIDE_ADD_SUB_EN adds sub_i for A-B.
// Revision : 1.0 - initial release
// ============================================================================

module carry_skip_adder #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int c_blocks = WIDTH / BLOCK_WIDTH;

  // Ripple inside each block; a fully-propagating block forwards its carry-in.
  always_comb begin
    logic w_blk_carry;
    logic w_rip_carry;
    logic w_prop;
    logic w_p;
    int   idx;
    sum         = '0;
    w_blk_carry = cin;
    for (int blk = 0; blk < c_blocks; blk++) begin
      w_rip_carry = w_blk_carry;
      w_prop      = 1'b1;
      for (int k = 0; k < BLOCK_WIDTH; k++) begin
        idx         = blk * BLOCK_WIDTH + k;
        w_p         = a[idx] ^ b[idx];
        sum[idx]    = w_p ^ w_rip_carry;
        w_rip_carry = (a[idx] & b[idx]) | (w_rip_carry & w_p);
        w_prop      = w_prop & w_p;
      end
      w_blk_carry = w_prop ? w_blk_carry : w_rip_carry;
    end
    cout = w_blk_carry;
  end

endmodule

module wide_add_sequencer #(
  parameter int DATA_WIDTH  = 128,
  parameter int SLICE_WIDTH = 32,
  parameter int BLOCK_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] operand_A_i,
  input  logic [DATA_WIDTH-1:0] operand_B_i,
  input  logic                  carry_i,
`ifdef WIDE_ADD_SUB_EN
  input  logic                  sub_i,
`endif
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  carry_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int c_slices = DATA_WIDTH / SLICE_WIDTH;
  localparam int c_cnt_w  = $clog2(c_slices) + 1;

  if (DATA_WIDTH % SLICE_WIDTH != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be an integer multiple of SLICE_WIDTH");
  end
  if (SLICE_WIDTH % BLOCK_WIDTH != 0) begin : g_bad_slice_width
    $error("SLICE_WIDTH must be an integer multiple of BLOCK_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_carry;
  logic [c_cnt_w-1:0]    r_cnt;

  logic                   w_accept;
  logic                   w_last;
  logic [SLICE_WIDTH-1:0] w_sum;
  logic                   w_cout;
  logic [DATA_WIDTH-1:0]  w_result_next;
  logic [DATA_WIDTH-1:0]  w_b_load;
  logic                   w_c_load;

`ifdef WIDE_ADD_SUB_EN
  // Subtraction is A + ~B + 1; carry out then means "no borrow".
  assign w_b_load = sub_i ? ~operand_B_i : operand_B_i;
  assign w_c_load = sub_i ? 1'b1 : carry_i;
`else
  assign w_b_load = operand_B_i;
  assign w_c_load = carry_i;
`endif

  carry_skip_adder #(
    .WIDTH       (SLICE_WIDTH),
    .BLOCK_WIDTH (BLOCK_WIDTH)
  ) u_adder (
    .a    (r_a[SLICE_WIDTH-1:0]),
    .b    (r_b[SLICE_WIDTH-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Each new slice enters at the MSB end so the LSB slice lands at bit 0.
  if (c_slices == 1) begin : g_single_slice
    assign w_result_next = w_sum;
  end else begin : g_multi_slice
    assign w_result_next = {w_sum, r_result[DATA_WIDTH-1:SLICE_WIDTH]};
  end

  assign w_last   = (r_cnt == c_cnt_w'(c_slices - 1));
  assign w_accept = valid_i & ready_o;
  assign result_o = r_result;
  assign carry_o  = r_carry;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          w_state_next = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        valid_o = 1'b1;
        ready_o = ready_i;
        if (ready_i) begin
          w_state_next = valid_i ? ST_COMPUTE : ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a     <= operand_A_i;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == ST_COMPUTE) begin
      r_a      <= r_a >> SLICE_WIDTH;
      r_b      <= r_b >> SLICE_WIDTH;
      r_result <= w_result_next;
      r_carry  <= w_cout;
      r_cnt    <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_add_sequencer
// Brief    : Directed and randomised checks of wide_add_sequencer (128/32/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wide_add_sequencer;

  localparam int DW = 128;
  localparam int SW = 32;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] operand_A_i;
  logic [DW-1:0] operand_B_i;
  logic          carry_i;
  logic          sub_i;
  logic [DW-1:0] result_o;
  logic          carry_o;
  logic          valid_o;
  logic          ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(
    .DATA_WIDTH  (DW),
    .SLICE_WIDTH (SW),
    .BLOCK_WIDTH (BW)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .operand_A_i (operand_A_i),
    .operand_B_i (operand_B_i),
    .carry_i     (carry_i),
`ifdef WIDE_ADD_SUB_EN
    .sub_i       (sub_i),
`endif
    .result_o    (result_o),
    .carry_o     (carry_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  // Called 1 time unit after a rising edge with ready_o high; returns just
  // after the accept edge.
  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic c, input logic s);
    valid_i     = 1'b1;
    operand_A_i = a;
    operand_B_i = b;
    carry_i     = c;
    sub_i       = s;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!valid_o && cyc < 20);
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    operand_A_i = '0;
    operand_B_i = '0;
    carry_i = 1'b0;
    sub_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 4;
    if (result_o !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result_o); end
    if (carry_o !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", carry_o); end
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_o); end
    rst_n_i = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_ready got %b want 1", ready_o); end
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", valid_o); end
  endtask

  task automatic test_overflow;
    int cyc;
    logic [DW-1:0] ones;
    ones = '1;
    issue(ones, 128'd1, 1'b0, 1'b0);
    wait_valid(cyc);
    n_checks += 3;
    if (cyc !== 4) begin n_fail++; $display("FAIL ovf_latency got %0d want 4", cyc); end
    if (result_o !== 128'd0) begin n_fail++; $display("FAIL ovf_result got %h want 0", result_o); end
    if (carry_o !== 1'b1) begin n_fail++; $display("FAIL ovf_carry got %b want 1", carry_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_carry_chain;
    int cyc;
    issue(128'h0000_0000_FFFF_FFFF, 128'd1, 1'b1, 1'b0);
    wait_valid(cyc);
    n_checks += 3;
    if (cyc !== 4) begin n_fail++; $display("FAIL chain_latency got %0d want 4", cyc); end
    if (result_o !== 128'h1_0000_0001) begin n_fail++; $display("FAIL chain_result got %h want 100000001", result_o); end
    if (carry_o !== 1'b0) begin n_fail++; $display("FAIL chain_carry got %b want 0", carry_o); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold;
    int cyc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   exp;
    a = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    b = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_FFFF_FFFF;
    exp = {1'b0, a} + {1'b0, b} + 129'd1;
    ready_i = 1'b0;
    issue(a, b, 1'b1, 1'b0);
    wait_valid(cyc);
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL hold_latency got %0d want 4", cyc); end
    for (int i = 0; i < 10; i++) begin
      valid_i     = 1'b1;
      operand_A_i = 128'h5555 + 128'(i);
      operand_B_i = 128'hAAAA;
      carry_i     = 1'b1;
      @(posedge clk);
      #1;
      n_checks += 4;
      if (valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got %b want 1", i, valid_o); end
      if (ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d] got %b want 0", i, ready_o); end
      if (result_o !== exp[DW-1:0]) begin n_fail++; $display("FAIL hold_result[%0d] got %h want %h", i, result_o, exp[DW-1:0]); end
      if (carry_o !== exp[DW]) begin n_fail++; $display("FAIL hold_carry[%0d] got %b want %b", i, carry_o, exp[DW]); end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got %b want 1", ready_o); end
    @(posedge clk);
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_exit_valid got %b want 0", valid_o); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          c;
    logic [DW:0]   exp;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = 1'($urandom_range(0, 1));
    exp = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
    issue(a, b, c, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      wait_valid(cyc);
      n_checks += 3;
      if (cyc !== 4) begin n_fail++; $display("FAIL b2b_latency[%0d] got %0d want 4", i, cyc); end
      if (result_o !== exp[DW-1:0]) begin n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", i, result_o, exp[DW-1:0]); end
      if (carry_o !== exp[DW]) begin n_fail++; $display("FAIL b2b_carry[%0d] got %b want %b", i, carry_o, exp[DW]); end
      if (i < 999) begin
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        if (i % 97 == 5) begin
          a = '1;
          b = 128'd0;
        end
        c = 1'($urandom_range(0, 1));
        exp = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
        n_checks++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", i, ready_o); end
        issue(a, b, c, 1'b0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    issue(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n_i = 1'b0;
    #1;
    n_checks += 4;
    if (result_o !== '0) begin n_fail++; $display("FAIL abort_result got %h want 0", result_o); end
    if (carry_o !== 1'b0) begin n_fail++; $display("FAIL abort_carry got %b want 0", carry_o); end
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", valid_o); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", ready_o); end
    #2;
    rst_n_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (valid_o) seen = 1'b1;
    end
    n_checks += 2;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid got %b want 0", seen); end
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ready got %b want 1", ready_o); end
  endtask

`ifdef WIDE_ADD_SUB_EN
  task automatic test_sub;
    int cyc;
    logic [DW-1:0] want;
    want = '1;
    want[0] = 1'b0;
    issue(128'd5, 128'd7, 1'b0, 1'b1);
    wait_valid(cyc);
    n_checks += 3;
    if (cyc !== 4) begin n_fail++; $display("FAIL sub_neg_latency got %0d want 4", cyc); end
    if (result_o !== want) begin n_fail++; $display("FAIL sub_neg_result got %h want %h", result_o, want); end
    if (carry_o !== 1'b0) begin n_fail++; $display("FAIL sub_neg_carry got %b want 0", carry_o); end
    @(posedge clk);
    #1;
    issue(128'd7, 128'd5, 1'b0, 1'b1);
    wait_valid(cyc);
    n_checks += 2;
    if (result_o !== 128'd2) begin n_fail++; $display("FAIL sub_pos_result got %h want 2", result_o); end
    if (carry_o !== 1'b1) begin n_fail++; $display("FAIL sub_pos_carry got %b want 1", carry_o); end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    test_reset();
    test_overflow();
    test_carry_chain();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef WIDE_ADD_SUB_EN
    test_sub();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
